// File: rtl/audio_sfx_sequencer.sv
// Sample-rate scheduler: picks explosion, shot, music or silence at each sample
// tick, fetches the sample from a shared synchronous ROM and drives the PWM byte.
module audio_sfx_sequencer #(
  parameter int          CLKS_PER_SAMPLE = 12500,
  parameter int          ADDR_W          = 16,
  parameter int          EXPL_BASE       = 2000,
  parameter int          EXPL_LEN        = 6000,
  parameter int          SHOT_BASE       = 0,
  parameter int          SHOT_LEN        = 2000,
  parameter int          MUSIC_BASE      = 8000,
  parameter int          MUSIC_LEN       = 40000,
  parameter logic [7:0]  SILENCE         = 8'd128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_expl,
  input  logic              trig_shot,
  input  logic              music_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        music_data,
  output logic              sample_tick,
  output logic [1:0]        active_src,
  output logic              busy_sfx,
  output logic [1:0]        fsm_state
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0]     TICK_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [ADDR_W-1:0] EXPL_B     = ADDR_W'(EXPL_BASE);
  localparam logic [ADDR_W-1:0] SHOT_B     = ADDR_W'(SHOT_BASE);
  localparam logic [ADDR_W-1:0] MUSIC_B    = ADDR_W'(MUSIC_BASE);
  localparam logic [ADDR_W-1:0] EXPL_LAST  = ADDR_W'(EXPL_LEN - 1);
  localparam logic [ADDR_W-1:0] SHOT_LAST  = ADDR_W'(SHOT_LEN - 1);
  localparam logic [ADDR_W-1:0] MUSIC_LAST = ADDR_W'(MUSIC_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  typedef enum logic [1:0] {
    SRC_SIL  = 2'd0,
    SRC_MUS  = 2'd1,
    SRC_SHOT = 2'd2,
    SRC_EXPL = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  logic [CW-1:0]     cnt;
  logic              pend_expl, pend_shot;
  src_t              src_q, src_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              sil_q;
  logic              pe, ps, expl_run, shot_run, start_shot, music_step;
  state_t            state_q, state_d;
  logic              load_data;

  assign sample_tick = (cnt == TICK_LAST);
  assign active_src  = src_q;
  assign busy_sfx    = (src_q == SRC_SHOT) || (src_q == SRC_EXPL);
  assign fsm_state   = state_q;

  // A trigger arriving in the tick cycle itself is folded in here so it wins that tick.
  always_comb begin
    pe         = pend_expl | trig_expl;
    ps         = pend_shot | trig_shot;
    expl_run   = (src_q == SRC_EXPL) && (off_q != EXPL_LAST);
    shot_run   = (src_q == SRC_SHOT) && (off_q != SHOT_LAST);
    start_shot = ps && !pe && !expl_run;
    src_d      = SRC_SIL;
    off_d      = off_q;
    addr_d     = rom_addr;
    music_step = 1'b0;
    if (pe) begin
      src_d  = SRC_EXPL;
      off_d  = '0;
      addr_d = EXPL_B;
    end else if (expl_run) begin
      src_d  = SRC_EXPL;
      off_d  = off_q + ONE;
      addr_d = EXPL_B + off_d;
    end else if (start_shot) begin
      src_d  = SRC_SHOT;
      off_d  = '0;
      addr_d = SHOT_B;
    end else if (shot_run) begin
      src_d  = SRC_SHOT;
      off_d  = off_q + ONE;
      addr_d = SHOT_B + off_d;
    end else if (music_en) begin
      src_d      = SRC_MUS;
      addr_d     = MUSIC_B + ptr_q;
      music_step = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      pend_expl <= 1'b0;
      pend_shot <= 1'b0;
      src_q     <= SRC_SIL;
      off_q     <= '0;
      ptr_q     <= '0;
      rom_addr  <= '0;
      sil_q     <= 1'b1;
    end else begin
      cnt       <= sample_tick ? '0 : cnt + CW'(1);
      pend_expl <= sample_tick ? 1'b0 : pe;
      pend_shot <= ps & ~(sample_tick & start_shot);
      if (sample_tick) begin
        src_q    <= src_d;
        off_q    <= off_d;
        rom_addr <= addr_d;
        sil_q    <= (src_d == SRC_SIL);
      end
      // The pointer is frozen during effects so music resumes where it paused.
      if (!music_en)
        ptr_q <= '0;
      else if (sample_tick && music_step)
        ptr_q <= (ptr_q == MUSIC_LAST) ? '0 : ptr_q + ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_data = 1'b0;
    case (state_q)
      ST_IDLE:  if (sample_tick) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_WAIT;
      ST_WAIT: begin
        load_data = 1'b1;
        state_d   = ST_LATCH;
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ROM data is valid during WAIT, so music_data is loaded on entry to LATCH (T+3).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      music_data <= SILENCE;
    end else begin
      state_q <= state_d;
      if (load_data)
        music_data <= sil_q ? SILENCE : rom_data;
    end
  end

endmodule
